reg_pipe: RTL and testbench

Parametrised, flow-controlled register pipeline for the decoder datapath. It generalises the single-bit clocked register to WIDTH bits and DEPTH stages. Each stage carries a valid flag, and the pipeline adds ready/valid backpressure, bubble collapsing, a synchronous flush and an occupancy count. It sits between decoder stages wherever a fixed register delay must also tolerate downstream stalls without losing or duplicating data.

---
 rtl/reg_pipe.sv | 80 ++++++++
 tb/tb_reg_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// Flow-controlled WIDTH x DEPTH register pipeline with per-stage valid flags,
// ready/valid backpressure, bubble collapsing, synchronous flush and occupancy count.
//
// Handshake: a beat moves across an interface only in a cycle where valid and
// ready are both high at the rising edge; valid never waits on ready upstream,
// and ready here may depend combinationally on out_ready.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count_q;
  logic             in_xfer;
  logic             out_xfer;

  // A stage can load when it is empty or its successor is loading; the chain
  // starts at out_ready and is walked from the output back to the entry.
  always_comb begin : rdy_chain
    logic chain;
    chain = out_ready;
    rdy   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !v[i] || chain;
      rdy[i] = chain;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign count     = count_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v       <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else if (flush) begin
      // Data registers keep their contents; only occupancy is cleared.
      v       <= '0;
      count_q <= '0;
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          data[0] <= in_data;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            data[i] <= data[i-1];
          end
        end
      end
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe: DEPTH=4 instance against a queue-of-beats model with
// positions, plus a directed DEPTH=1 instance.
module tb_reg_pipe;

  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   count;

  logic         rst1_n = 1'b0, flush1 = 1'b0, in_valid1 = 1'b1, out_ready1 = 1'b0;
  logic [W-1:0] in_data1 = 8'hFF;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [0:0]   count1;

  reg_pipe #(.WIDTH(W), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  reg_pipe #(.WIDTH(W), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .flush(flush1),
    .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
    .count(count1)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds accepted beats oldest-first; exp_pos is each beat's slot index.
  logic [W-1:0] exp_q[$];
  int           exp_pos[$];
  int           npos[$];
  bit           popped;
  logic         exp_in_ready, exp_out_valid;
  logic [W-1:0] exp_last = '0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    else n_pass++;
  endtask

  // Each beat advances one slot unless it would collide with the beat ahead.
  function automatic void predict(input logic ordy, input logic fl);
    int bound, np;
    npos.delete();
    exp_out_valid = (exp_q.size() > 0) && (exp_pos[0] == D - 1);
    popped = exp_out_valid && ordy;
    bound = D;
    for (int k = (popped ? 1 : 0); k < exp_q.size(); k++) begin
      np = exp_pos[k] + 1;
      if (np > bound - 1) np = bound - 1;
      npos.push_back(np);
      bound = np;
    end
    exp_in_ready = !fl && (bound >= 1);
  endfunction

  function automatic void update(input logic rv, input logic fl, input logic iv, input logic [W-1:0] id);
    if (!rv || fl) begin
      exp_q.delete();
      exp_pos.delete();
      if (!rv) exp_last = '0;
    end else begin
      if (popped) begin
        void'(exp_q.pop_front());
        void'(exp_pos.pop_front());
      end
      for (int k = 0; k < npos.size(); k++) begin
        if (npos[k] == D - 1 && exp_pos[k] != D - 1) exp_last = exp_q[k];
        exp_pos[k] = npos[k];
      end
      if (iv && exp_in_ready) begin
        exp_q.push_back(id);
        exp_pos.push_back(0);
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic rv, input logic fl, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input bit chk, output bit acc);
    @(negedge clk);
    rst_n = rv; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    predict(ordy, fl);
    if (chk) begin
      check("in_ready", 32'(in_ready), 32'(exp_in_ready));
      check("out_valid", 32'(out_valid), 32'(exp_out_valid));
      check("out_data", 32'(out_data), 32'(exp_last));
      check("count", 32'(count), 32'(exp_q.size()));
    end
    acc = rv && iv && exp_in_ready;
    @(posedge clk);
    update(rv, fl, iv, id);
  endtask

  task automatic push(input logic [W-1:0] d, input logic ordy);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b1, d, ordy, 1'b1, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input logic ordy);
    bit acc;
    cycle(1'b1, 1'b0, 1'b0, '0, ordy, 1'b1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit acc;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, acc);
    idle(1'b0);

    for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
    drain();

    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, acc);
    check("full_stall", 32'(acc), 32'd0);
    push(8'hA4, 1'b1);
    push(8'hA5, 1'b1);
    drain();

    push(8'h5A, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    for (int i = 0; i < 3; i++) push(8'h5B + 8'(i), 1'b0);
    idle(1'b0);
    drain();

    for (int i = 0; i < 3; i++) push(8'hC1 + 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, acc);
    idle(1'b0);
    push(8'h88, 1'b1);
    drain();

    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
            1'b1, acc);
    drain();

    // DEPTH=1 instance, held in reset with in_valid=1/0xFF up to here.
    @(negedge clk);
    rst1_n = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h10; out_ready1 = 1'b1;
    #1;
    check("d1_rst_ready", 32'(in_ready1), 32'd1);
    check("d1_rst_valid", 32'(out_valid1), 32'd0);
    check("d1_rst_count", 32'(count1), 32'd0);
    check("d1_rst_data", 32'(out_data1), 32'h00);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      in_data1 = 8'h10 + 8'(k);
      #1;
      check("d1_tput_valid", 32'(out_valid1), 32'd1);
      check("d1_tput_data", 32'(out_data1), 32'h10 + 32'(k - 1));
      check("d1_tput_ready", 32'(in_ready1), 32'd1);
      check("d1_tput_count", 32'(count1), 32'd1);
    end
    @(negedge clk);
    out_ready1 = 1'b0; in_data1 = 8'h20;
    #1;
    check("d1_full_ready", 32'(in_ready1), 32'd0);
    check("d1_full_data", 32'(out_data1), 32'h16);
    @(negedge clk);
    rst1_n = 1'b0; flush1 = 1'b1;
    @(negedge clk);
    rst1_n = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0;
    #1;
    check("d1_rf_count", 32'(count1), 32'd0);
    check("d1_rf_valid", 32'(out_valid1), 32'd0);
    check("d1_rf_data", 32'(out_data1), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
